// File: rtl/reservation_station_mc_pkg.sv
// Shared fcpu back-end widths and the CDB broadcast record.
// Operand slot type is width-fixed here; entry layout lives with the station.
package reservation_station_mc_pkg;
  localparam int RSV_ID_W = 4;
  localparam int INSTR_W  = 8;
  localparam int DATA_W   = 16;
  localparam int CDB_W    = RSV_ID_W + DATA_W;

  typedef struct packed {
    logic [RSV_ID_W-1:0] rsv_id;
    logic [DATA_W-1:0]   data;
  } cdb_t;

  typedef struct packed {
    logic                filled;
    logic [RSV_ID_W-1:0] rsv_id;
    logic [DATA_W-1:0]   data;
  } opnd_t;

  function automatic logic tag_hit(input logic vld, input cdb_t bus, input logic [RSV_ID_W-1:0] tag);
    return vld && (bus.rsv_id == tag);
  endfunction
endpackage

// File: rtl/reservation_station_mc_if.sv
// Dispatch, issue, CDB and flush signals of the reservation station.
// master = dispatch/FU/CDB side, slave = the station itself.
interface reservation_station_mc_if #(
  parameter int N_OPERANDS   = 2,
  parameter int N_STATIONS_W = 3,
  parameter int N_CDB        = 2
);
  import reservation_station_mc_pkg::*;

  localparam int IN_W  = RSV_ID_W + INSTR_W + N_OPERANDS * CDB_W;
  localparam int OUT_W = RSV_ID_W + INSTR_W + N_OPERANDS * DATA_W;

  logic                    i_valid;
  logic                    i_ordered;
  logic [IN_W-1:0]         i_data;
  logic [N_OPERANDS-1:0]   i_filled;
  logic                    i_ready;
  logic                    o_valid;
  logic [OUT_W-1:0]        o_data;
  logic                    o_ready;
  logic [N_CDB-1:0]        cdb_valid;
  logic [N_CDB*CDB_W-1:0]  cdb;
  logic                    flush;
  logic [N_STATIONS_W:0]   o_count;

  modport master (
    output i_valid, i_ordered, i_data, i_filled, o_ready, cdb_valid, cdb, flush,
    input  i_ready, o_valid, o_data, o_count
  );

  modport slave (
    input  i_valid, i_ordered, i_data, i_filled, o_ready, cdb_valid, cdb, flush,
    output i_ready, o_valid, o_data, o_count
  );
endinterface

// File: rtl/reservation_station_mc_picker.sv
// Combinational oldest-first picker: grants the ready entry that has no older ready entry.
// older[i][j] = entry j is older than entry i; the matrix is a total order over valid entries.
module rsv_age_picker #(
  parameter int N = 8
) (
  input  logic [N-1:0]         ready,
  input  logic [N-1:0][N-1:0]  older,
  output logic [N-1:0]         grant,
  output logic                 grant_valid
);
  always_comb begin
    grant = '0;
    for (int i = 0; i < N; i++) begin
      grant[i] = ready[i] & ~|(ready & older[i]);
    end
  end

  assign grant_valid = |ready;
endmodule

// File: rtl/reservation_station_mc.sv
// Age-ordered multi-CDB reservation station; issues the oldest ready entry, ordered entries in order.
// Insert/wake at t -> issue request at t+1; o_valid holds under o_ready=0; i_ready drops only when full.
module reservation_station_mc
  import reservation_station_mc_pkg::*;
#(
  parameter int N_OPERANDS   = 2,
  parameter int N_STATIONS_W = 3,
  parameter int N_CDB        = 2
) (
  input logic                     clk,
  input logic                     nrst,
  reservation_station_mc_if.slave bus
);
  localparam int N     = 1 << N_STATIONS_W;
  localparam int OUT_W = RSV_ID_W + INSTR_W + N_OPERANDS * DATA_W;

  typedef struct packed {
    logic                           ordered;
    logic [RSV_ID_W-1:0]            rob_id;
    logic [INSTR_W-1:0]             opcode;
    opnd_t [N_OPERANDS-1:0]         ops;
  } entry_t;

  entry_t                 ent_q [N];
  entry_t                 ent_d [N];
  entry_t                 new_ent;
  entry_t                 sel_ent;
  logic [N-1:0]           valid_q, valid_d;
  logic [N-1:0][N-1:0]    older_q, older_d;
  logic [N_STATIONS_W:0]  count_q, count_d;

  logic [N-1:0]           ordered_vec, all_filled, ready, grant;
  logic                   grant_vld;
  logic                   has_free, ins_fire, out_vld, issue_fire;
  logic [N_STATIONS_W-1:0] ins_idx;
  logic [OUT_W-1:0]       out_dat;
  cdb_t [N_CDB-1:0]       cdb_bus;

  assign cdb_bus = bus.cdb;

  // Lowest-index bus wins when several broadcast the same tag.
  function automatic opnd_t capture(input opnd_t op, input logic [N_CDB-1:0] v, input cdb_t [N_CDB-1:0] b);
    opnd_t r;
    r = op;
    if (!op.filled) begin
      for (int c = N_CDB - 1; c >= 0; c--) begin
        if (tag_hit(v[c], b[c], op.rsv_id)) begin
          r.filled = 1'b1;
          r.data   = b[c].data;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    ordered_vec = '0;
    all_filled  = '1;
    for (int i = 0; i < N; i++) begin
      ordered_vec[i] = ent_q[i].ordered;
      for (int o = 0; o < N_OPERANDS; o++) begin
        if (!ent_q[i].ops[o].filled) all_filled[i] = 1'b0;
      end
    end
  end

  // An ordered entry waits for every older valid ordered entry, ready or not.
  always_comb begin
    ready = '0;
    for (int i = 0; i < N; i++) begin
      ready[i] = valid_q[i] & all_filled[i] &
                 (~ent_q[i].ordered | ~|(valid_q & ordered_vec & older_q[i]));
    end
  end

  rsv_age_picker #(.N(N)) u_picker (
    .ready       (ready),
    .older       (older_q),
    .grant       (grant),
    .grant_valid (grant_vld)
  );

  assign has_free   = ~&valid_q;
  assign out_vld    = grant_vld & ~bus.flush & ~nrst;
  assign issue_fire = out_vld & bus.o_ready;
  assign ins_fire   = bus.i_valid & has_free & ~bus.flush & ~nrst;

  always_comb begin
    ins_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!valid_q[i]) ins_idx = N_STATIONS_W'(i);
    end
  end

  always_comb begin
    new_ent         = '0;
    new_ent.ordered = bus.i_ordered;
    new_ent.opcode  = bus.i_data[N_OPERANDS*CDB_W +: INSTR_W];
    new_ent.rob_id  = bus.i_data[N_OPERANDS*CDB_W+INSTR_W +: RSV_ID_W];
    for (int o = 0; o < N_OPERANDS; o++) begin
      new_ent.ops[o].filled = bus.i_filled[o];
      new_ent.ops[o].rsv_id = bus.i_data[o*CDB_W+DATA_W +: RSV_ID_W];
      new_ent.ops[o].data   = bus.i_data[o*CDB_W +: DATA_W];
      new_ent.ops[o]        = capture(new_ent.ops[o], bus.cdb_valid, cdb_bus);
    end
  end

  always_comb begin
    valid_d = valid_q;
    older_d = older_q;
    for (int i = 0; i < N; i++) begin
      ent_d[i] = ent_q[i];
      if (valid_q[i]) begin
        for (int o = 0; o < N_OPERANDS; o++) begin
          ent_d[i].ops[o] = capture(ent_q[i].ops[o], bus.cdb_valid, cdb_bus);
        end
      end
    end
    if (issue_fire) valid_d = valid_d & ~grant;
    // New entry is younger than everything currently held.
    if (ins_fire) begin
      valid_d[ins_idx] = 1'b1;
      ent_d[ins_idx]   = new_ent;
      older_d[ins_idx] = valid_q;
      for (int i = 0; i < N; i++) older_d[i][ins_idx] = 1'b0;
    end
    if (bus.flush) valid_d = '0;
  end

  always_comb begin
    count_d = '0;
    for (int i = 0; i < N; i++) count_d = count_d + (N_STATIONS_W+1)'(valid_d[i]);
  end

  always_comb begin
    sel_ent = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) sel_ent = ent_q[i];
    end
    out_dat = '0;
    if (out_vld) begin
      out_dat[N_OPERANDS*DATA_W +: INSTR_W]          = sel_ent.opcode;
      out_dat[N_OPERANDS*DATA_W+INSTR_W +: RSV_ID_W] = sel_ent.rob_id;
      for (int o = 0; o < N_OPERANDS; o++) out_dat[o*DATA_W +: DATA_W] = sel_ent.ops[o].data;
    end
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      valid_q <= '0;
      older_q <= '0;
      count_q <= '0;
      for (int i = 0; i < N; i++) ent_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      older_q <= older_d;
      count_q <= count_d;
      for (int i = 0; i < N; i++) ent_q[i] <= ent_d[i];
    end
  end

  assign bus.i_ready = has_free & ~nrst;
  assign bus.o_valid = out_vld;
  assign bus.o_data  = out_dat;
  assign bus.o_count = nrst ? '0 : count_q;
endmodule

// File: tb/tb_reservation_station_mc.sv
// Random + directed stimulus against an in-order queue model of the reservation station.
module tb_reservation_station_mc;
  import reservation_station_mc_pkg::*;

  localparam int OUT_W = RSV_ID_W + INSTR_W + 2 * DATA_W;
  localparam int IN_W  = RSV_ID_W + INSTR_W + 2 * CDB_W;
  localparam int CAP   = 8;

  typedef struct packed {
    logic                       nrst;
    logic                       i_valid;
    logic                       i_ordered;
    logic [1:0]                 i_filled;
    logic [RSV_ID_W-1:0]        rob;
    logic [INSTR_W-1:0]         opc;
    logic [1:0][RSV_ID_W-1:0]   tag;
    logic [1:0][DATA_W-1:0]     dat;
    logic                       o_ready;
    logic [1:0]                 cdb_valid;
    logic [1:0][RSV_ID_W-1:0]   ctag;
    logic [1:0][DATA_W-1:0]     cdat;
    logic                       flush;
  } stim_t;

  typedef struct {
    logic                       ord;
    logic [RSV_ID_W-1:0]        rob;
    logic [INSTR_W-1:0]         opc;
    logic [1:0]                 filled;
    logic [1:0][RSV_ID_W-1:0]   tag;
    logic [1:0][DATA_W-1:0]     dat;
  } ment_t;

  logic clk = 1'b0;
  logic nrst = 1'b1;
  always #5 clk = ~clk;

  reservation_station_mc_if #(.N_OPERANDS(2), .N_STATIONS_W(3), .N_CDB(2)) bus ();

  reservation_station_mc #(.N_OPERANDS(2), .N_STATIONS_W(3), .N_CDB(2)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  ment_t            mq [$];
  logic [OUT_W-1:0] exp_q [$];
  logic             exp_i_ready, exp_o_valid, armed = 1'b0;
  int               exp_count;
  int               total = 0, bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  // Drive one cycle, predict outputs from the model, then advance the model.
  task automatic step(input stim_t s);
    int    sel;
    bit    seen_ord, cap_ok, hit;
    logic  ov;
    ment_t e;
    @(posedge clk);
    #1;
    nrst          = s.nrst;
    bus.i_valid   = s.i_valid;
    bus.i_ordered = s.i_ordered;
    bus.i_filled  = s.i_filled;
    bus.i_data    = IN_W'({s.rob, s.opc, s.tag[1], s.dat[1], s.tag[0], s.dat[0]});
    bus.o_ready   = s.o_ready;
    bus.cdb_valid = s.cdb_valid;
    bus.cdb       = {s.ctag[1], s.cdat[1], s.ctag[0], s.cdat[0]};
    bus.flush     = s.flush;

    sel = -1;
    seen_ord = 0;
    for (int k = 0; k < mq.size(); k++) begin
      if (sel < 0 && mq[k].filled == 2'b11 && !(mq[k].ord && seen_ord)) sel = k;
      if (mq[k].ord) seen_ord = 1;
    end
    ov          = (sel >= 0) && !s.flush && !s.nrst;
    exp_o_valid = ov;
    exp_i_ready = !s.nrst && (mq.size() < CAP);
    exp_count   = s.nrst ? 0 : mq.size();
    if (ov && s.o_ready) exp_q.push_back({mq[sel].rob, mq[sel].opc, mq[sel].dat});

    if (s.nrst || s.flush) begin
      mq.delete();
    end else begin
      cap_ok = mq.size() < CAP;
      for (int k = 0; k < mq.size(); k++) begin
        for (int o = 0; o < 2; o++) begin
          hit = 0;
          for (int c = 0; c < 2; c++) begin
            if (!mq[k].filled[o] && !hit && s.cdb_valid[c] && s.ctag[c] == mq[k].tag[o]) begin
              hit = 1;
              mq[k].filled[o] = 1'b1;
              mq[k].dat[o]    = s.cdat[c];
            end
          end
        end
      end
      if (ov && s.o_ready) mq.delete(sel);
      if (s.i_valid && cap_ok) begin
        e.ord = s.i_ordered; e.rob = s.rob; e.opc = s.opc;
        e.filled = s.i_filled; e.tag = s.tag; e.dat = s.dat;
        for (int o = 0; o < 2; o++) begin
          hit = 0;
          for (int c = 0; c < 2; c++) begin
            if (!e.filled[o] && !hit && s.cdb_valid[c] && s.ctag[c] == e.tag[o]) begin
              hit = 1;
              e.filled[o] = 1'b1;
              e.dat[o]    = s.cdat[c];
            end
          end
        end
        mq.push_back(e);
      end
    end
    armed = 1'b1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        check("i_ready", 64'(bus.i_ready), 64'(exp_i_ready));
        check("o_count", 64'(bus.o_count), 64'(exp_count));
        check("o_valid", 64'(bus.o_valid), 64'(exp_o_valid));
        if (!exp_o_valid) check("o_data_idle", 64'(bus.o_data), 64'd0);
        if (bus.o_valid && bus.o_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL issue_unexpected: got o_data %0h expected no issue at %0t", bus.o_data, $time);
          end else begin
            check("o_data", 64'(bus.o_data), 64'(exp_q.pop_front()));
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic stim_t rand_stim();
    stim_t s;
    s = '0;
    s.nrst      = ($urandom_range(0, 199) == 0);
    s.i_valid   = ($urandom_range(0, 2) != 0);
    s.i_ordered = ($urandom_range(0, 3) == 0);
    s.i_filled  = 2'($urandom);
    s.rob       = RSV_ID_W'($urandom);
    s.opc       = INSTR_W'($urandom);
    for (int o = 0; o < 2; o++) begin
      s.tag[o]  = RSV_ID_W'($urandom_range(0, 7));
      s.dat[o]  = DATA_W'($urandom);
      s.ctag[o] = RSV_ID_W'($urandom_range(0, 7));
      s.cdat[o] = DATA_W'($urandom);
    end
    s.o_ready   = ($urandom_range(0, 3) != 0);
    s.cdb_valid = 2'($urandom);
    s.flush     = ($urandom_range(0, 59) == 0);
    return s;
  endfunction

  initial begin
    stim_t s;
    bus.i_valid = 0; bus.i_ordered = 0; bus.i_filled = '0; bus.i_data = '0;
    bus.o_ready = 0; bus.cdb_valid = '0; bus.cdb = '0; bus.flush = 0;

    s = idle(); s.nrst = 1'b1;
    repeat (3) step(s);

    // Fill to capacity, a 9th request is dropped, then drain in insert order.
    for (int k = 0; k < 9; k++) begin
      s = idle(); s.i_valid = 1; s.i_filled = 2'b11;
      s.rob = RSV_ID_W'(k); s.opc = INSTR_W'(8'h10 + k);
      s.dat[0] = DATA_W'(2 * k); s.dat[1] = DATA_W'(2 * k + 1);
      step(s);
    end
    s = idle(); s.o_ready = 1;
    repeat (9) step(s);

    // Oldest-first: A waits on tag 5, B is ready and goes first.
    s = idle(); s.i_valid = 1; s.i_filled = 2'b01; s.rob = 4'd1; s.opc = 8'hA1;
    s.dat[0] = 16'h0A0A; s.tag[1] = 4'd5; step(s);
    s = idle(); s.i_valid = 1; s.i_filled = 2'b11; s.rob = 4'd2; s.opc = 8'hB2;
    s.dat = {16'h2222, 16'h1111}; s.o_ready = 1; step(s);
    s = idle(); s.o_ready = 1; step(s);
    s = idle(); s.o_ready = 1; s.cdb_valid = 2'b01; s.ctag[0] = 4'd5; s.cdat[0] = 16'h1234; step(s);
    s = idle(); s.o_ready = 1; repeat (2) step(s);

    // Insert-cycle bypass from both buses, then both buses carrying one tag.
    s = idle(); s.i_valid = 1; s.rob = 4'd3; s.opc = 8'hC3; s.tag = {4'd4, 4'd3};
    s.cdb_valid = 2'b11; s.ctag = {4'd4, 4'd3}; s.cdat = {16'h00BB, 16'h00AA}; s.o_ready = 1; step(s);
    s = idle(); s.o_ready = 1; step(s);
    s = idle(); s.i_valid = 1; s.rob = 4'd4; s.opc = 8'hC4; s.tag = {4'd3, 4'd3};
    s.cdb_valid = 2'b11; s.ctag = {4'd3, 4'd3}; s.cdat = {16'h00DD, 16'h00CC}; s.o_ready = 1; step(s);
    s = idle(); s.o_ready = 1; repeat (2) step(s);

    // Ordered X (waiting), ordered Y, unordered Z: Z first, then X, then Y.
    s = idle(); s.i_valid = 1; s.i_ordered = 1; s.i_filled = 2'b01; s.tag[1] = 4'd7; s.rob = 4'd5; step(s);
    s = idle(); s.i_valid = 1; s.i_ordered = 1; s.i_filled = 2'b11; s.rob = 4'd6; s.dat = {16'h6666, 16'h6060}; step(s);
    s = idle(); s.i_valid = 1; s.i_filled = 2'b11; s.rob = 4'd7; s.dat = {16'h7777, 16'h7070}; step(s);
    s = idle(); s.o_ready = 1; repeat (2) step(s);
    s = idle(); s.o_ready = 1; s.cdb_valid = 2'b10; s.ctag[1] = 4'd7; s.cdat[1] = 16'h5555; step(s);
    s = idle(); s.o_ready = 1; repeat (3) step(s);

    // Flush with 5 entries while inserting and accepting.
    for (int k = 0; k < 5; k++) begin
      s = idle(); s.i_valid = 1; s.i_filled = 2'b11; s.rob = RSV_ID_W'(k + 8); step(s);
    end
    s = idle(); s.flush = 1; s.i_valid = 1; s.i_filled = 2'b11; s.o_ready = 1; step(s);
    s = idle(); s.o_ready = 1; repeat (2) step(s);

    // Reset mid-operation; a stale tag afterwards must not wake anything.
    for (int k = 0; k < 3; k++) begin
      s = idle(); s.i_valid = 1; s.i_filled = 2'b01; s.tag[1] = 4'd9; s.rob = RSV_ID_W'(k); step(s);
    end
    s = idle(); s.nrst = 1; step(s);
    s = idle(); s.o_ready = 1; s.cdb_valid = 2'b01; s.ctag[0] = 4'd9; step(s);
    s = idle(); s.o_ready = 1; repeat (2) step(s);

    repeat (3000) step(rand_stim());

    for (int k = 0; k < 300 && mq.size() > 0; k++) begin
      s = idle(); s.o_ready = 1; s.cdb_valid = 2'b11;
      s.ctag = {RSV_ID_W'($urandom_range(0, 7)), RSV_ID_W'($urandom_range(0, 7))};
      s.cdat = {DATA_W'($urandom), DATA_W'($urandom)};
      step(s);
    end
    s = idle(); s.o_ready = 1; repeat (2) step(s);
    @(negedge clk);
    #1;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    check("model_drained", 64'(mq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reservation_station_mc.md
Name: reservation_station_mc

Overview:
Multi-CDB, age-ordered reservation station for the fcpu out-of-order back end. It sits between dispatch and one functional unit (ALU, FPU or LSU).
- Holds up to 2**N_STATIONS_W instructions.
- Wakes operands from N_CDB parallel common data buses, including wake-up in the cycle of insertion.
- Issues the oldest ready entry.
- Enforces in-order issue among entries tagged "ordered" (memory ops).
- Supports a single-cycle pipeline flush.

Parameters:
N_OPERANDS, 2, source operands per instruction (1..3)
N_STATIONS_W, 3, log2 of entry count
N_CDB, 2, number of CDB broadcast ports (1..4)

Ports:
clk  in  1  clock
nrst  in  1  reset, synchronous, active-high
i_valid  in  1  dispatch request
i_ordered  in  1  entry must issue in order with other ordered entries
i_data  in  RSV_ID_W+INSTR_W+N_OPERANDS*(RSV_ID_W+DATA_W)  {rob_id, opcode, op[N-1..0]}; each op = {rsv_id, data}, op0 in the LSBs
i_filled  in  N_OPERANDS  operand already holds valid data
i_ready  out  1  a free entry exists
o_valid  out  1  issue request
o_data  out  RSV_ID_W+INSTR_W+N_OPERANDS*DATA_W  {rob_id, opcode, data[N-1..0]}
o_ready  in  1  functional unit accepts
cdb_valid  in  N_CDB  per-bus valid
cdb  in  N_CDB*CDB_W  per bus {rsv_id at DATA_W+:RSV_ID_W, data at 0+:DATA_W}
flush  in  1  discard all entries
o_count  out  N_STATIONS_W+1  occupied entries

Behaviour:
- Reset (nrst=1 at a clk edge):
  - All entries become invalid; age matrix is cleared.
  - o_valid=0, o_data=0, o_count=0, i_ready=0 while nrst is high.
  - i_ready=1 in the first cycle after nrst deasserts.
  - Reset mid-operation drops all contents; no partial state survives.
- Entry state: valid, ordered, rob_id, opcode, and per operand filled/rsv_id/data. Age matrix older[i][j] = entry j is older than entry i.
- i_ready:
  - Asserted when any entry is invalid in registered state.
  - Independent of o_ready and flush.
  - An entry freed by issue is not reusable until the next cycle.
- Insert (i_valid & i_ready & ~flush):
  - Writes the lowest-index free entry.
  - Row older[k] is set to the current valid vector; column older[*][k] is cleared.
- Insert-cycle bypass: for each operand with i_filled=0, if any cdb_valid[c] has a tag equal to the operand rsv_id, the entry stores that bus's data with filled=1. If several buses match, the lowest c wins.
- Wake-up:
  - A valid entry with an unfilled operand whose tag matches a valid CDB captures data and sets filled next cycle; the lowest c wins.
  - Filled operands ignore the CDB.
- Ready(i) = valid & all filled & (~ordered | no valid ordered entry j with older[i][j]).
- Select: the ready entry with no older ready entry.
  - o_valid = any ready & ~flush.
  - o_data is driven from the selected entry, or 0 when o_valid=0.
  - o_valid is combinational from registered state.
  - Latency: insert with all operands filled at cycle t → o_valid at t+1. CDB match at t → o_valid at t+1.
- Issue (o_valid & o_ready): the selected entry is invalidated next cycle. One issue per cycle.
- o_valid holds while o_ready=0. Selection may change only if an older entry becomes ready.
- Simultaneous insert + issue + wake-up in one cycle: all take effect; o_count is unchanged.
- Flush:
  - All entries are invalid and o_count=0 next cycle.
  - Insert and issue in the flush cycle are suppressed.
  - CDB traffic in the flush cycle is ignored.
- Full: i_ready=0; i_valid is ignored, with no overwrite.
- Empty: o_valid=0.
- o_count is a registered population count.

Decomposition:
- fcpu_pkg holds RSV_ID_W, INSTR_W, DATA_W, CDB_W, and a new typedef cdb_t {rsv_id, data}.
- The entry struct stays local to the module because it depends on N_OPERANDS.
- One sub-module: rsv_age_picker, parametrised by N entries. Inputs are the ready vector and the age matrix; outputs are a one-hot grant and grant_valid. It is purely combinational and reused by later LSU queues.

Test Plan:
Default parameters apply unless stated.
- Fill and full: 8 inserts, all filled, o_ready=0 → i_ready falls after the 8th accept; o_count=8; a 9th i_valid is ignored. Then o_ready=1 → 8 issues in insert order, one per cycle.
- Oldest-first: insert A (op1 waits on tag 5), then B (all filled) → B issues first. CDB0 {5, 0x1234} → A issues next cycle with data1=0x1234.
- Insert bypass and dual CDB:
  - Insert with op0 tag 3 and op1 tag 4, both unfilled, while cdb0={3, 0xAA} and cdb1={4, 0xBB} → o_valid next cycle with data {0xBB, 0xAA}.
  - Repeat with both buses carrying tag 3 → cdb0 data is taken.
- Ordered: insert ordered X (op waiting on tag 7), then ordered Y (filled), then unordered Z (filled) → Z issues, Y is held; after CDB tag 7, X issues, then Y.
- Flush: 5 valid entries, flush=1 together with i_valid and o_ready → no issue, no insert; next cycle o_count=0, o_valid=0, i_ready=1.
- Reset mid-operation: nrst=1 for one cycle with 3 entries → all outputs at reset values; a stale CDB tag after release causes no issue.
